// File: rtl/wimax_iq_pkg.sv
// rtl/wimax_iq_pkg.sv - shared types and constants for the WiMAX I/Q framer
package wimax_iq_pkg;

  localparam int IQ_W              = 16;
  localparam int BLOCK_LEN_DEFAULT = 96;

  localparam logic [IQ_W-1:0] QPSK_POS = 16'h5A82;
  localparam logic [IQ_W-1:0] QPSK_NEG = 16'hA57E;

  typedef enum logic {
    IDLE,
    STREAM
  } framer_state_t;

  typedef struct packed {
    logic [IQ_W-1:0] I;
    logic [IQ_W-1:0] Q;
  } iq_sample_t;

  // True when a sample component sits on one of the two legal constellation levels
  function automatic logic is_qpsk_level(input logic [IQ_W-1:0] v,
                                         input logic [IQ_W-1:0] pos,
                                         input logic [IQ_W-1:0] neg);
    return (v == pos) || (v == neg);
  endfunction

endpackage

// File: rtl/wimax_iq_fifo.sv
// rtl/wimax_iq_fifo.sv - synchronous show-ahead FIFO of I/Q samples
module wimax_iq_fifo
  import wimax_iq_pkg::*;
#(
  parameter int DEPTH = 128,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [2*IQ_W-1:0] wr_data,
  output logic [2*IQ_W-1:0] rd_data,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  iq_sample_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Sample storage; contents are meaningless until counted in, so no reset
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= iq_sample_t'(wr_data);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // Head entry is presented combinationally; forced to zero when nothing is stored
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/wimax_iq_framer.sv
// rtl/wimax_iq_framer.sv - store-and-forward block framer for QPSK I/Q (option: IQ_LEVEL_CHECK_EN)
module wimax_iq_framer
  import wimax_iq_pkg::*;
#(
  parameter int BLOCK_LEN  = BLOCK_LEN_DEFAULT,
  parameter int DATA_W     = IQ_W,
  parameter int FIFO_DEPTH = 128
`ifdef IQ_LEVEL_CHECK_EN
  ,
  parameter logic [IQ_W-1:0] POS_LEVEL = QPSK_POS,
  parameter logic [IQ_W-1:0] NEG_LEVEL = QPSK_NEG
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_I,
  input  logic [DATA_W-1:0] in_Q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_I,
  output logic [DATA_W-1:0] out_Q,
  output logic              out_sop,
  output logic              out_eop,
  output logic [15:0]       block_count,
  output logic              err_level
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SC_W  = $clog2(BLOCK_LEN);
  localparam logic [SC_W-1:0]  LAST_SYM  = SC_W'(BLOCK_LEN - 1);
  localparam logic [CNT_W-1:0] BLOCK_CNT = CNT_W'(BLOCK_LEN);

  framer_state_t     state;
  logic [SC_W-1:0]   sym_cnt;
  logic [CNT_W-1:0]  fill;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [2*IQ_W-1:0] head;

  // Ready follows the registered fill level only, so a full FIFO refuses even during a pop
  assign in_ready = ~reset & ~full;
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready & ~empty;

  assign out_I = head[2*IQ_W-1:IQ_W];
  assign out_Q = head[IQ_W-1:0];

  wimax_iq_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .wr_data({in_I, in_Q}),
    .rd_data(head),
    .count  (fill),
    .full   (full),
    .empty  (empty)
  );

  // Block FSM: wait for a whole block to be buffered, then stream it with markers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sym_cnt     <= '0;
      out_valid   <= 1'b0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      block_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fill >= BLOCK_CNT) begin
            state     <= STREAM;
            sym_cnt   <= '0;
            out_valid <= 1'b1;
            out_sop   <= 1'b1;
            out_eop   <= (LAST_SYM == '0);
          end
        end
        STREAM: begin
          if (pop) begin
            out_sop <= 1'b0;
            if (sym_cnt == LAST_SYM) begin
              state       <= IDLE;
              sym_cnt     <= '0;
              out_valid   <= 1'b0;
              out_eop     <= 1'b0;
              block_count <= block_count + 1'b1;
            end else begin
              sym_cnt <= sym_cnt + 1'b1;
              out_eop <= (sym_cnt == LAST_SYM - 1'b1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IQ_LEVEL_CHECK_EN
  // Sticky flag for any accepted sample whose I or Q is off the legal levels
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_level <= 1'b0;
    end else if (push && !(is_qpsk_level(in_I, POS_LEVEL, NEG_LEVEL) &&
                           is_qpsk_level(in_Q, POS_LEVEL, NEG_LEVEL))) begin
      err_level <= 1'b1;
    end
  end
`else
  assign err_level = 1'b0;
`endif

endmodule

// File: tb/tb_wimax_iq_framer.sv
// tb/tb_wimax_iq_framer.sv - self-checking bench for wimax_iq_framer
module tb_wimax_iq_framer;

  localparam int BL    = 96;
  localparam int DEPTH = 128;
`ifdef IQ_LEVEL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_I;
  logic [15:0] in_Q;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_I;
  logic [15:0] out_Q;
  logic        out_sop;
  logic        out_eop;
  logic [15:0] block_count;
  logic        err_level;

  wimax_iq_framer dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_I       (in_I),
    .in_Q       (in_Q),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_I      (out_I),
    .out_Q      (out_Q),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .block_count(block_count),
    .err_level  (err_level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] mq[$];
  int          mcnt  = 0;
  logic [15:0] mbc   = 16'd0;
  int          gen_k = 0;

  typedef struct {
    logic [15:0] i0;
    logic [15:0] q0;
    logic [15:0] step;
    int          stall_at;
    int          stall_len;
    logic [15:0] exp_bc;
  } vec_t;

  vec_t vt[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] gen_sample(input int k);
    logic [15:0] v;
    v = 16'h4000 + k[15:0];
    return {v, ~v};
  endfunction

  task automatic push_one(input logic [15:0] i, input logic [15:0] q);
    logic acc;
    acc      = (mcnt < DEPTH);
    in_valid = 1'b1;
    in_I     = i;
    in_Q     = q;
    check("in_ready", {31'd0, in_ready}, {31'd0, acc});
    @(negedge clock);
    in_valid = 1'b0;
    if (acc) begin
      mq.push_back({i, q});
      mcnt++;
    end
  endtask

  task automatic drain(input int n, input int stall_at, input int stall_len, input int n_feed);
    int          idx;
    int          stalled;
    int          budget;
    int          fed;
    logic [31:0] s;
    logic        acc;
    idx = 0; stalled = 0; budget = 0; fed = 0; s = '0;
    while (!out_valid && budget < 300) begin
      @(negedge clock);
      budget++;
    end
    check("valid_wait", {31'd0, out_valid}, 32'd1);
    if (!out_valid) return;
    while (idx < n && budget < 2000) begin
      check("out_valid", {31'd0, out_valid}, 32'd1);
      check("out_data", {out_I, out_Q}, mq[0]);
      check("out_sop", {31'd0, out_sop}, {31'd0, idx == 0});
      check("out_eop", {31'd0, out_eop}, {31'd0, idx == BL - 1});
      if (idx == stall_at && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
      end
      acc = 1'b0;
      if (fed < n_feed) begin
        s        = gen_sample(gen_k);
        in_valid = 1'b1;
        in_I     = s[31:16];
        in_Q     = s[15:0];
        acc      = (mcnt < DEPTH);
        check("feed_ready", {31'd0, in_ready}, {31'd0, acc});
      end
      @(negedge clock);
      in_valid = 1'b0;
      if (out_ready) begin
        void'(mq.pop_front());
        idx++;
        mcnt--;
        if (idx == BL) mbc++;
      end
      if (acc) begin
        mq.push_back(s);
        mcnt++;
        gen_k++;
        fed++;
      end
      budget++;
    end
    out_ready = 1'b0;
    check("drain_done", idx, n);
    if (n == BL) begin
      check("idle_gap", {31'd0, out_valid}, 32'd0);
      check("block_count", {16'd0, block_count}, {16'd0, mbc});
    end
  endtask

  initial begin
    logic        saw;
    logic [31:0] s;
    vt[0] = '{16'h5A82, 16'hA57E, 16'h0000, -1, 0, 16'd1};
    vt[1] = '{16'h0001, 16'h8000, 16'h0001, 40, 10, 16'd2};
    vt[2] = '{16'hFFF0, 16'h0100, 16'h0003, 0, 3, 16'd3};
    vt[3] = '{16'h1000, 16'h2000, 16'h0007, 95, 5, 16'd4};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_I = '0; in_Q = '0;
    repeat (2) @(negedge clock);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sop_eop", {30'd0, out_sop, out_eop}, 32'd0);
    check("rst_out_iq", {out_I, out_Q}, 32'd0);
    check("rst_block_count", {16'd0, block_count}, 32'd0);
    check("rst_err", {31'd0, err_level}, 32'd0);
    reset = 1'b0;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("rel_out_valid", {31'd0, out_valid}, 32'd0);

    // Table: full blocks with different data patterns and stall placements
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < BL; k++) begin
        push_one(vt[v].i0 + vt[v].step * 16'(k), vt[v].q0 - vt[v].step * 16'(k));
      end
      check("lat_n1", {31'd0, out_valid}, 32'd0);
      @(negedge clock);
      check("lat_n2", {31'd0, out_valid}, 32'd1);
      drain(BL, vt[v].stall_at, vt[v].stall_len, 0);
      check("tbl_bc", {16'd0, block_count}, {16'd0, vt[v].exp_bc});
    end

    // Overfill with no drain: 128 accepted, two refused
    for (int k = 0; k < 130; k++) begin
      s = gen_sample(gen_k);
      gen_k++;
      push_one(s[31:16], s[15:0]);
    end
    check("full_ready", {31'd0, in_ready}, 32'd0);
    drain(BL, -1, 0, 0);
    saw = 1'b0;
    repeat (5) begin
      if (out_valid) saw = 1'b1;
      @(negedge clock);
    end
    check("resid_no_valid", {31'd0, saw}, 32'd0);
    check("resid_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back blocks: exactly one idle cycle between them
    for (int k = 0; k < 64; k++) begin
      s = gen_sample(gen_k);
      gen_k++;
      push_one(s[31:16], s[15:0]);
    end
    drain(BL, -1, 0, BL);
    @(negedge clock);
    check("gap_valid", {31'd0, out_valid}, 32'd1);
    check("gap_sop", {31'd0, out_sop}, 32'd1);
    drain(BL, -1, 0, 0);

    // 95 samples never release a block
    for (int k = 0; k < BL - 1; k++) begin
      s = gen_sample(gen_k);
      gen_k++;
      push_one(s[31:16], s[15:0]);
    end
    saw = 1'b0;
    repeat (200) begin
      if (out_valid) saw = 1'b1;
      @(negedge clock);
    end
    check("hold95", {31'd0, saw}, 32'd0);
    s = gen_sample(gen_k);
    gen_k++;
    push_one(s[31:16], s[15:0]);
    check("lat96_n1", {31'd0, out_valid}, 32'd0);
    @(negedge clock);
    check("lat96_n2", {31'd0, out_valid}, 32'd1);
    drain(BL, -1, 0, 0);

    // Reset in the middle of a block
    for (int k = 0; k < BL; k++) begin
      push_one(k[0] ? 16'h5A82 : 16'hA57E, k[1] ? 16'h5A82 : 16'hA57E);
    end
    drain(40, -1, 0, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_sop_eop", {30'd0, out_sop, out_eop}, 32'd0);
    check("mid_rst_iq", {out_I, out_Q}, 32'd0);
    check("mid_rst_bc", {16'd0, block_count}, 32'd0);
    check("mid_rst_err", {31'd0, err_level}, 32'd0);
    mq.delete();
    mcnt = 0;
    mbc  = 16'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("mid_rel_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < BL; k++) begin
      push_one(k[1] ? 16'hA57E : 16'h5A82, k[0] ? 16'hA57E : 16'h5A82);
    end
    drain(BL, -1, 0, 0);

    // Illegal level: flagged only when the checker is built in, data unchanged
    check("err_clean", {31'd0, err_level}, 32'd0);
    push_one(16'h1234, 16'hA57E);
    check("err_set", {31'd0, err_level}, {31'd0, EXP_ERR});
    repeat (300) @(negedge clock);
    check("err_hold", {31'd0, err_level}, {31'd0, EXP_ERR});
    for (int k = 1; k < BL; k++) begin
      push_one(16'h5A82, k[0] ? 16'hA57E : 16'h5A82);
    end
    drain(BL, -1, 0, 0);
    check("err_final", {31'd0, err_level}, {31'd0, EXP_ERR});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
